// File: rtl/mips_sram_pkg.sv
// Shared types and configuration checks for the two-port bit-masked SRAM.
// Feature macro used by the top: MIPS_TPBMSRAM_BYPASS_EN.
package mips_sram_pkg;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } init_state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   function automatic logic cfg_ok(
      input int rd_lat,
      input int addr_width,
      input int depth
   );
      logic ok;
      ok = (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
      ok = ok && (depth >= 1);
      ok = ok && (addr_width >= 1) && (addr_width <= 31);
      ok = ok && ((longint'(1) << addr_width) >= longint'(depth));
      return ok;
   endfunction

   // Depth need not be a power of two, so addresses are range-checked.
   function automatic logic in_range(
      input logic [31:0] addr,
      input int unsigned depth
   );
      return addr < depth;
   endfunction

endpackage

// File: rtl/mips_sram_init_seq.sv
// Init sweep sequencer: writes every word once after reset, then
// holds READY and raises init_done until the next reset.
module mips_sram_init_seq
   import mips_sram_pkg::*;
#(
   parameter int MEM_DEPTH  = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  init_we,
   output logic [ADDR_WIDTH-1:0] init_addr,
   output logic                  init_done
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

   init_state_t           state;
   init_state_t           state_nxt;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [ADDR_WIDTH-1:0] cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      init_we   = 1'b0;
      init_done = 1'b0;
      case (state)
         ST_INIT: begin
            init_we = 1'b1;
            cnt_nxt = cnt + ADDR_WIDTH'(1);
            if (cnt == LAST) begin
               state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            init_done = 1'b1;
         end
      endcase
   end

   assign init_addr = cnt;

endmodule

// File: rtl/mips_tpbmsram.sv
// Two-port (1W+1R) bit-masked SRAM with self-init sweep and RD_LAT read pipe.
// Define MIPS_TPBMSRAM_BYPASS_EN for write-through on same-address collision.
module mips_tpbmsram
   import mips_sram_pkg::*;
#(
   parameter int                   MEM_WIDTH  = 32,
   parameter int                   MEM_DEPTH  = 256,
   parameter int                   ADDR_WIDTH = 8,
   parameter int                   RD_LAT     = 1,
   parameter logic [MEM_WIDTH-1:0] INIT_VAL   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_ce,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [MEM_WIDTH-1:0]  wr_din,
   input  logic [MEM_WIDTH-1:0]  wr_wbeb,
   input  logic                  rd_ce,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [MEM_WIDTH-1:0]  rd_dout,
   output logic                  rd_vld,
   output logic                  init_done
);

   if (!cfg_ok(RD_LAT, ADDR_WIDTH, MEM_DEPTH)) begin : g_cfg_err
      $error("mips_tpbmsram: illegal RD_LAT/ADDR_WIDTH/MEM_DEPTH");
   end

   logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];

   logic                  init_we;
   logic [ADDR_WIDTH-1:0] init_addr;

   logic                  we;
   logic [ADDR_WIDTH-1:0] wa;
   logic [MEM_WIDTH-1:0]  wd;
   logic [MEM_WIDTH-1:0]  wm;
   logic                  wr_user;

   logic                  rd_hit;
   logic                  rd_ok;
   logic [MEM_WIDTH-1:0]  rd_data;

   mips_sram_init_seq #(
      .MEM_DEPTH  (MEM_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_init (
      .clk       (clk),
      .rst       (rst),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_done (init_done)
   );

   // User ports are only live once the sweep has finished.
   assign wr_user = init_done && wr_ce
                 && in_range(32'(wr_addr), MEM_DEPTH);
   assign rd_hit  = init_done && rd_ce;
   assign rd_ok   = in_range(32'(rd_addr), MEM_DEPTH);

   always_comb begin
      we = wr_user;
      wa = wr_addr;
      wd = wr_din;
      wm = wr_wbeb;
      if (init_we) begin
         we = 1'b1;
         wa = init_addr;
         wd = INIT_VAL;
         wm = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= (mem[wa] & ~wm) | (wd & wm);
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_ok) begin
         rd_data = mem[rd_addr];
      end
`ifdef MIPS_TPBMSRAM_BYPASS_EN
      if (rd_ok && wr_user && (wr_addr == rd_addr)) begin
         rd_data = (wr_din & wr_wbeb) | (rd_data & ~wr_wbeb);
      end
`endif
   end

   if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_vld  <= 1'b0;
            rd_dout <= '0;
         end else begin
            rd_vld <= rd_hit;
            if (rd_hit) begin
               rd_dout <= rd_data;
            end
         end
      end
   end else begin : g_lat2
      logic                 s1_vld;
      logic [MEM_WIDTH-1:0] s1_data;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            rd_vld  <= 1'b0;
            rd_dout <= '0;
         end else begin
            s1_vld <= rd_hit;
            if (rd_hit) begin
               s1_data <= rd_data;
            end
            rd_vld <= s1_vld;
            if (s1_vld) begin
               rd_dout <= s1_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_tpbmsram.sv
// Bench for mips_tpbmsram: two instances (256/lat1/DEADBEEF, 200/lat2/0)
// driven by shared directed stimulus, checked against a behavioural model.
module tb_mips_tpbmsram;

   localparam int          DEP_A  = 256;
   localparam int          DEP_B  = 200;
   localparam int          LAT_A  = 1;
   localparam int          LAT_B  = 2;
   localparam logic [31:0] INIT_A = 32'hDEAD_BEEF;
   localparam logic [31:0] INIT_B = 32'h0000_0000;
`ifdef MIPS_TPBMSRAM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_ce = 1'b0;
   logic [7:0]  wr_addr = '0;
   logic [31:0] wr_din = '0;
   logic [31:0] wr_wbeb = '0;
   logic        rd_ce = 1'b0;
   logic [7:0]  rd_addr = '0;

   logic [31:0] dout_a, dout_b;
   logic        vld_a, vld_b, done_a, done_b;

   always #5 clk = ~clk;

   mips_tpbmsram #(
      .MEM_WIDTH(32), .MEM_DEPTH(DEP_A), .ADDR_WIDTH(8),
      .RD_LAT(LAT_A), .INIT_VAL(INIT_A)
   ) dut_a (
      .clk(clk), .rst(rst),
      .wr_ce(wr_ce), .wr_addr(wr_addr), .wr_din(wr_din), .wr_wbeb(wr_wbeb),
      .rd_ce(rd_ce), .rd_addr(rd_addr),
      .rd_dout(dout_a), .rd_vld(vld_a), .init_done(done_a)
   );

   mips_tpbmsram #(
      .MEM_WIDTH(32), .MEM_DEPTH(DEP_B), .ADDR_WIDTH(8),
      .RD_LAT(LAT_B), .INIT_VAL(INIT_B)
   ) dut_b (
      .clk(clk), .rst(rst),
      .wr_ce(wr_ce), .wr_addr(wr_addr), .wr_din(wr_din), .wr_wbeb(wr_wbeb),
      .rd_ce(rd_ce), .rd_addr(rd_addr),
      .rd_dout(dout_b), .rd_vld(vld_b), .init_done(done_b)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dep(input int k);
      return (k == 0) ? DEP_A : DEP_B;
   endfunction

   function automatic int lat(input int k);
      return (k == 0) ? LAT_A : LAT_B;
   endfunction

   function automatic logic [31:0] ini(input int k);
      return (k == 0) ? INIT_A : INIT_B;
   endfunction

   // Behavioural model: cycles since reset release, word array, and a
   // result delay of lat(k) edges from request to visible output.
   logic [31:0] mm [2][256];
   int          mcnt [2];
   bit          pv [2];
   logic [31:0] pd [2];
   bit          ev [2];
   logic [31:0] ed [2];
   bit          rdy, sv;
   logic [31:0] sd;

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            mcnt[k] = 0;
            pv[k] = 1'b0;
            pd[k] = '0;
            ev[k] = 1'b0;
            ed[k] = '0;
         end else begin
            rdy = (mcnt[k] == dep(k));
            sv = 1'b0;
            sd = '0;
            if (rdy && rd_ce) begin
               sv = 1'b1;
               if (int'(rd_addr) < dep(k)) begin
                  sd = mm[k][rd_addr];
                  if (BYP && wr_ce && wr_addr == rd_addr)
                     sd = (wr_din & wr_wbeb) | (sd & ~wr_wbeb);
               end
            end
            if (rdy && wr_ce && int'(wr_addr) < dep(k))
               mm[k][wr_addr] = (wr_din & wr_wbeb) | (mm[k][wr_addr] & ~wr_wbeb);
            if (!rdy) begin
               mcnt[k]++;
               if (mcnt[k] == dep(k))
                  for (int a = 0; a < 256; a++) mm[k][a] = ini(k);
            end
            if (lat(k) == 1) begin
               ev[k] = sv;
               if (sv) ed[k] = sd;
            end else begin
               ev[k] = pv[k];
               if (pv[k]) ed[k] = pd[k];
               pv[k] = sv;
               pd[k] = sd;
            end
         end
      end
   end

   bit started = 1'b0;

   always @(negedge clk) begin
      if (started) begin
         chk("m_done_a", 32'(done_a), 32'(mcnt[0] == DEP_A));
         chk("m_done_b", 32'(done_b), 32'(mcnt[1] == DEP_B));
         chk("m_vld_a", 32'(vld_a), 32'(ev[0]));
         chk("m_vld_b", 32'(vld_b), 32'(ev[1]));
         chk("m_dout_a", dout_a, ed[0]);
         chk("m_dout_b", dout_b, ed[1]);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_wr(input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] m);
      wr_ce = 1'b1; wr_addr = a; wr_din = d; wr_wbeb = m;
      cyc();
      wr_ce = 1'b0;
   endtask

   task automatic do_rd(input string nm, input logic [7:0] a,
                        input logic [31:0] ea, input logic [31:0] eb);
      rd_ce = 1'b1; rd_addr = a;
      cyc();
      rd_ce = 1'b0;
      chk({nm, "_vld_a"}, 32'(vld_a), 32'd1);
      chk({nm, "_a"}, dout_a, ea);
      cyc();
      chk({nm, "_vld_b"}, 32'(vld_b), 32'd1);
      chk({nm, "_b"}, dout_b, eb);
   endtask

   task automatic do_coll(input string nm, input logic [7:0] a,
                          input logic [31:0] d, input logic [31:0] m,
                          input logic [31:0] olda, input logic [31:0] oldb);
      logic [31:0] na, nb;
      na = (d & m) | (olda & ~m);
      nb = (d & m) | (oldb & ~m);
      wr_ce = 1'b1; wr_addr = a; wr_din = d; wr_wbeb = m;
      rd_ce = 1'b1; rd_addr = a;
      cyc();
      wr_ce = 1'b0; rd_ce = 1'b0;
      chk({nm, "_coll_a"}, dout_a, BYP ? na : olda);
      cyc();
      chk({nm, "_coll_b"}, dout_b, BYP ? nb : oldb);
      do_rd({nm, "_after"}, a, na, nb);
   endtask

   task automatic wait_init(output int ca, output int cb, input int noise);
      int n;
      n = 0; ca = -1; cb = -1;
      while ((ca < 0 || cb < 0) && n < 600) begin
         if (n < noise) begin
            wr_ce = 1'b1; wr_addr = 8'd3; wr_din = 32'h5555_5555;
            wr_wbeb = '1; rd_ce = 1'b1; rd_addr = 8'd3;
         end else begin
            wr_ce = 1'b0; rd_ce = 1'b0;
         end
         cyc();
         n++;
         if (n < noise) begin
            chk("init_vld_a", 32'(vld_a), 32'd0);
            chk("init_vld_b", 32'(vld_b), 32'd0);
         end
         if (done_a && ca < 0) ca = n;
         if (done_b && cb < 0) cb = n;
      end
      wr_ce = 1'b0; rd_ce = 1'b0;
   endtask

   function automatic logic [31:0] bdat(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
   endfunction

   int ca, cb;

   initial begin
      repeat (3) cyc();
      started = 1'b1;
      chk("rst_done_a", 32'(done_a), 32'd0);
      chk("rst_vld_a", 32'(vld_a), 32'd0);
      chk("rst_dout_a", dout_a, 32'd0);
      chk("rst_done_b", 32'(done_b), 32'd0);
      chk("rst_vld_b", 32'(vld_b), 32'd0);
      chk("rst_dout_b", dout_b, 32'd0);

      rst = 1'b0;
      wait_init(ca, cb, 0);
      chk("init_cycles_a", ca, 256);
      chk("init_cycles_b", cb, 200);

      do_rd("rd0", 8'd0, 32'hDEAD_BEEF, 32'h0);
      do_rd("rd255", 8'd255, 32'hDEAD_BEEF, 32'h0);

      do_wr(8'd5, 32'hFFFF_FFFF, 32'h0000_FF00);
      do_rd("mask5", 8'd5, 32'hDEAD_FFEF, 32'h0000_FF00);
      do_wr(8'd5, 32'h0000_0000, 32'h0000_0000);
      do_rd("nomask5", 8'd5, 32'hDEAD_FFEF, 32'h0000_FF00);

      do_coll("a7", 8'd7, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0);
      do_coll("a8", 8'd8, 32'h1234_5678, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'h0);

      for (int i = 0; i < 16; i++) do_wr(8'(i), bdat(i), '1);
      for (int i = 0; i < 16; i++) begin
         rd_ce = 1'b1; rd_addr = 8'(i);
         cyc();
         chk("burst_vld_a", 32'(vld_a), 32'd1);
         chk("burst_a", dout_a, bdat(i));
         chk("burst_vld_b", 32'(vld_b), 32'(i > 0));
         if (i > 0) chk("burst_b", dout_b, bdat(i - 1));
      end
      rd_ce = 1'b0;
      cyc();
      chk("burst_end_vld_a", 32'(vld_a), 32'd0);
      chk("burst_hold_a", dout_a, bdat(15));
      chk("burst_end_vld_b", 32'(vld_b), 32'd1);
      chk("burst_last_b", dout_b, bdat(15));
      cyc();
      chk("burst_idle_vld_b", 32'(vld_b), 32'd0);
      chk("burst_hold_b", dout_b, bdat(15));

      do_wr(8'd210, 32'hCAFE_F00D, '1);
      do_rd("oor210", 8'd210, 32'hCAFE_F00D, 32'h0);
      do_rd("edge199", 8'd199, 32'hDEAD_BEEF, 32'h0);

      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         wr_ce = 1'b1; wr_addr = 8'd3; wr_din = 32'h5555_5555;
         wr_wbeb = '1; rd_ce = 1'b1; rd_addr = 8'd3;
         cyc();
         chk("sweep_vld_a", 32'(vld_a), 32'd0);
         chk("sweep_vld_b", 32'(vld_b), 32'd0);
      end
      wr_ce = 1'b0; rd_ce = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      wait_init(ca, cb, 150);
      chk("reinit_cycles_a", ca, 256);
      chk("reinit_cycles_b", cb, 200);
      do_rd("noland3", 8'd3, 32'hDEAD_BEEF, 32'h0);

      repeat (2) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
